// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  // Default number of cycles to wait for the transmitter to report busy.
  localparam int DEFAULT_BUSY_TIMEOUT = 8;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  // Result of a round-robin pick between the two requesters.
  typedef struct packed {
    logic valid;  // at least one eligible requester
    logic idx;    // winning requester index
  } rr_pick_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake signals of the UART transmit arbiter.
// master: the requesters plus the transmitter; slave: the arbiter itself.
interface uart_tx_arbiter_if;
  logic       req0;
  logic       req1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       lock0;
  logic       lock1;
  logic       ack0;
  logic       ack1;
  logic [1:0] grant;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       timeout;

  modport master (
    output req0, req1, data0, data1, lock0, lock1, tx_busy,
    input  ack0, ack1, grant, tx_wr, tx_data, timeout
  );

  modport slave (
    input  req0, req1, data0, data1, lock0, lock1, tx_busy,
    output ack0, ack1, grant, tx_wr, tx_data, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter in front of a byte-wide UART transmitter.
// A requester may lock ownership across a multi-byte message. tx_wr waits for
// the transmitter to be idle, and a missing busy response is reported as a
// timeout so the arbiter never stalls.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic              clk,
  input  logic              resetq,
  uart_tx_arbiter_if.slave  bus
);

  localparam int               CNT_W   = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TIMEOUT);

  // Round-robin pick: on a tie the requester not granted last wins.
  function automatic rr_pick_t rr_pick(input logic [1:0] elig, input logic last);
    rr_pick_t p;
    p.valid = |elig;
    if (elig == 2'b11) p.idx = ~last;
    else               p.idx = elig[1];
    return p;
  endfunction

  arb_state_e       state, state_n;
  logic [7:0]       tx_data_q;
  logic [1:0]       grant_q;
  logic [CNT_W-1:0] busy_cnt;
  logic             lock_held;
  logic             lock_owner;
  logic             last_idx;

  logic [1:0]       req_vec;
  logic [1:0]       lock_vec;
  logic [1:0]       own_mask;
  logic [1:0]       elig;
  logic             lock_live;
  logic             owner_idx;
  rr_pick_t         pick;

  logic             load;
  logic             tx_wr;
  logic             timeout;
  logic             done_exit;

  assign req_vec   = {bus.req1, bus.req0};
  assign lock_vec  = {bus.lock1, bus.lock0};
  assign owner_idx = grant_q[1];

  // A held lock only counts while its owner still drives lock, so a falling
  // lock releases ownership in the same IDLE cycle.
  assign lock_live = lock_held & lock_vec[lock_owner];
  assign own_mask  = lock_owner ? 2'b10 : 2'b01;
  assign elig      = lock_live ? (req_vec & own_mask) : req_vec;
  assign pick      = rr_pick(elig, last_idx);

  // State register.
  always_ff @(posedge clk or negedge resetq) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!resetq) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state decode and strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    state_n   = state;
    load      = 1'b0;
    tx_wr     = 1'b0;
    timeout   = 1'b0;
    done_exit = 1'b0;
    case (state)
      IDLE: begin
        if (pick.valid) begin
          load    = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.tx_busy) begin
          tx_wr   = 1'b1;
          state_n = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_n = WAIT_DONE;
        end else if (busy_cnt == CNT_MAX) begin
          timeout = 1'b1;
          state_n = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          done_exit = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Latch the winning byte and owner; drop ownership when the transfer ends.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_data_q <= 8'h00;
      grant_q   <= 2'b00;
    end else if (load) begin
      tx_data_q <= pick.idx ? bus.data1 : bus.data0;
      grant_q   <= pick.idx ? 2'b10 : 2'b01;
    end else if (done_exit || timeout) begin
      grant_q   <= 2'b00;
    end
  end

  // Saturating wait-for-busy counter, held at zero outside WAIT_BUSY.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)                 busy_cnt <= '0;
    else if (state != WAIT_BUSY) busy_cnt <= '0;
    else if (busy_cnt != CNT_MAX) busy_cnt <= busy_cnt + CNT_W'(1);
  end

  // Lock ownership and round-robin history; a timed-out byte changes neither.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      lock_held  <= 1'b0;
      lock_owner <= 1'b0;
      last_idx   <= 1'b1;
    end else if (done_exit) begin
      lock_held  <= lock_vec[owner_idx];
      lock_owner <= owner_idx;
      last_idx   <= owner_idx;
    end else if (state == IDLE && lock_held && !lock_vec[lock_owner]) begin
      lock_held  <= 1'b0;
    end
  end

  assign bus.tx_wr   = tx_wr;
  assign bus.tx_data = tx_data_q;
  assign bus.grant   = grant_q;
  assign bus.ack0    = tx_wr & grant_q[0];
  assign bus.ack1    = tx_wr & grant_q[1];
  assign bus.timeout = timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single byte, round-robin,
// locked message, busy timeout, busy hold-off and mid-transfer reset.
module tb_uart_tx_arbiter;

  localparam int BT = 8;

  logic clk = 1'b0;
  logic resetq;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.BUSY_TIMEOUT(BT)) dut (
    .clk    (clk),
    .resetq (resetq),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Outputs sampled at the falling edge.
  logic       s_tx_wr, s_ack0, s_ack1, s_timeout;
  logic [1:0] s_grant;
  logic [7:0] s_tx_data;

  // Transmitter model: busy rises the cycle after a write, stays up busy_cycles.
  bit model_on;
  bit start_pending;
  int busy_left;
  int busy_cycles = 10;

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.data0 = 8'h00; bus.data1 = 8'h00;
    bus.lock0 = 1'b0; bus.lock1 = 1'b0;
    bus.tx_busy = 1'b0;
    model_on = 1'b0; start_pending = 1'b0; busy_left = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetq = 1'b0;
    repeat (2) @(negedge clk);
    resetq = 1'b1;
  endtask

  task automatic cycle();
    @(negedge clk);
    s_tx_wr   = bus.tx_wr;
    s_ack0    = bus.ack0;
    s_ack1    = bus.ack1;
    s_timeout = bus.timeout;
    s_grant   = bus.grant;
    s_tx_data = bus.tx_data;
    if (model_on) begin
      if (start_pending) begin
        bus.tx_busy = 1'b1; busy_left = busy_cycles; start_pending = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) bus.tx_busy = 1'b0;
      end
      if (s_tx_wr) start_pending = 1'b1;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    resetq = 1'b1;
    bus.req0 = 1'b1; bus.data0 = 8'hEE; bus.lock0 = 1'b1;
    @(negedge clk);
    #2 resetq = 1'b0;
    #1;
    checks++; if (bus.tx_wr !== 1'b0) begin failures++; $display("FAIL reset_tx_wr: got %b want 0", bus.tx_wr); end
    checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    checks++; if ({bus.ack1, bus.ack0} !== 2'b00) begin failures++; $display("FAIL reset_ack: got %b want 00", {bus.ack1, bus.ack0}); end
    checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b want 00", bus.grant); end
    checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", bus.timeout); end
    repeat (3) begin
      cycle();
      checks++;
      if (s_grant !== 2'b00 || s_tx_wr !== 1'b0 || s_ack0 !== 1'b0) begin
        failures++; $display("FAIL reset_hold: grant %b tx_wr %b ack0 %b want 00/0/0", s_grant, s_tx_wr, s_ack0);
      end
    end
    idle_inputs();
    resetq = 1'b1;
  endtask

  task automatic test_single();
    int extra;
    bit back_idle;
    do_reset();
    model_on = 1'b1;
    @(negedge clk);
    bus.data0 = 8'h41; bus.req0 = 1'b1;
    cycle();
    checks++; if (s_tx_wr !== 1'b1) begin failures++; $display("FAIL single_tx_wr: got %b want 1", s_tx_wr); end
    checks++; if ({s_ack1, s_ack0} !== 2'b01) begin failures++; $display("FAIL single_ack: got %b want 01", {s_ack1, s_ack0}); end
    checks++; if (s_tx_data !== 8'h41) begin failures++; $display("FAIL single_tx_data: got %h want 41", s_tx_data); end
    checks++; if (s_grant !== 2'b01) begin failures++; $display("FAIL single_grant: got %b want 01", s_grant); end
    bus.req0 = 1'b0;
    extra = 0; back_idle = 1'b0;
    for (int i = 0; i < 30 && !back_idle; i++) begin
      cycle();
      if (s_ack0 || s_ack1 || s_tx_wr) extra++;
      if (s_grant == 2'b00) back_idle = 1'b1;
    end
    checks++; if (!back_idle) begin failures++; $display("FAIL single_release: grant %b want 00 within 30 cycles", s_grant); end
    checks++; if (extra != 0) begin failures++; $display("FAIL single_dup: got %0d extra strobes want 0", extra); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_byte [4];
    logic [1:0] exp_ack [4];
    int got;
    exp_byte[0] = 8'h30; exp_byte[1] = 8'h31; exp_byte[2] = 8'h30; exp_byte[3] = 8'h31;
    exp_ack[0]  = 2'b01; exp_ack[1]  = 2'b10; exp_ack[2]  = 2'b01; exp_ack[3]  = 2'b10;
    do_reset();
    model_on = 1'b1;
    @(negedge clk);
    bus.data0 = 8'h30; bus.data1 = 8'h31; bus.req0 = 1'b1; bus.req1 = 1'b1;
    got = 0;
    for (int i = 0; i < 120 && got < 4; i++) begin
      cycle();
      if (s_tx_wr) begin
        checks++; if (s_tx_data !== exp_byte[got]) begin failures++; $display("FAIL rr_byte%0d: got %h want %h", got, s_tx_data, exp_byte[got]); end
        checks++; if ({s_ack1, s_ack0} !== exp_ack[got]) begin failures++; $display("FAIL rr_ack%0d: got %b want %b", got, {s_ack1, s_ack0}, exp_ack[got]); end
        got++;
      end
    end
    checks++; if (got != 4) begin failures++; $display("FAIL rr_count: got %0d bytes want 4", got); end
    idle_inputs();
  endtask

  task automatic test_lock();
    logic [7:0] exp_byte [4];
    int got;
    exp_byte[0] = 8'h01; exp_byte[1] = 8'h02; exp_byte[2] = 8'h03; exp_byte[3] = 8'h55;
    do_reset();
    model_on = 1'b1;
    @(negedge clk);
    bus.data0 = 8'h01; bus.req0 = 1'b1; bus.lock0 = 1'b1;
    bus.data1 = 8'h55; bus.req1 = 1'b1;
    got = 0;
    for (int i = 0; i < 120 && got < 4; i++) begin
      cycle();
      if (s_tx_wr) begin
        checks++; if (s_tx_data !== exp_byte[got]) begin failures++; $display("FAIL lock_byte%0d: got %h want %h", got, s_tx_data, exp_byte[got]); end
        got++;
        if (s_ack0) begin
          case (got)
            1: bus.data0 = 8'h02;
            2: bus.data0 = 8'h03;
            default: begin bus.req0 = 1'b0; bus.lock0 = 1'b0; end
          endcase
        end
      end
    end
    checks++; if (got != 4) begin failures++; $display("FAIL lock_count: got %0d bytes want 4", got); end
    idle_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    @(negedge clk);
    bus.data0 = 8'hAA; bus.req0 = 1'b1;
    cycle();
    checks++; if (s_tx_wr !== 1'b1) begin failures++; $display("FAIL to_first_wr: got %b want 1", s_tx_wr); end
    bus.req0 = 1'b0; bus.data1 = 8'hBB; bus.req1 = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      cycle();
      if (k <= 9) begin
        checks++;
        if (s_timeout !== (k == 9)) begin failures++; $display("FAIL to_pulse_k%0d: got %b want %b", k, s_timeout, (k == 9)); end
      end
      if (k == 9) begin
        checks++; if (s_grant !== 2'b01) begin failures++; $display("FAIL to_grant_held: got %b want 01", s_grant); end
      end
      if (k == 10) begin
        checks++; if (s_grant !== 2'b00 || s_timeout !== 1'b0) begin failures++; $display("FAIL to_idle: grant %b timeout %b want 00/0", s_grant, s_timeout); end
      end
      if (k == 11) begin
        checks++; if (s_tx_wr !== 1'b1 || s_ack1 !== 1'b1) begin failures++; $display("FAIL to_next_wr: tx_wr %b ack1 %b want 1/1", s_tx_wr, s_ack1); end
        checks++; if (s_tx_data !== 8'hBB) begin failures++; $display("FAIL to_next_data: got %h want BB", s_tx_data); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_busy_hold();
    int acks;
    do_reset();
    bus.tx_busy = 1'b1;
    @(negedge clk);
    bus.data1 = 8'hC3; bus.req1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (s_tx_wr !== 1'b0 || s_ack1 !== 1'b0) begin failures++; $display("FAIL hold_c%0d: tx_wr %b ack1 %b want 0/0", i, s_tx_wr, s_ack1); end
    end
    checks++; if (s_grant !== 2'b10) begin failures++; $display("FAIL hold_grant: got %b want 10", s_grant); end
    bus.req1 = 1'b0;
    bus.tx_busy = 1'b0;
    #1;
    checks++; if (bus.tx_wr !== 1'b1 || bus.ack1 !== 1'b1 || bus.ack0 !== 1'b0) begin failures++; $display("FAIL hold_release: tx_wr %b ack %b want 1/10", bus.tx_wr, {bus.ack1, bus.ack0}); end
    checks++; if (bus.tx_data !== 8'hC3) begin failures++; $display("FAIL hold_data: got %h want C3", bus.tx_data); end
    model_on = 1'b1; start_pending = 1'b1;
    acks = 0;
    for (int i = 0; i < 25; i++) begin
      cycle();
      if (s_ack0 || s_ack1) acks++;
    end
    checks++; if (acks != 0) begin failures++; $display("FAIL hold_dup: got %0d extra acks want 0", acks); end
    checks++; if (s_grant !== 2'b00) begin failures++; $display("FAIL hold_end_grant: got %b want 00", s_grant); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int acks;
    do_reset();
    model_on = 1'b1;
    @(negedge clk);
    bus.data0 = 8'h5A; bus.req0 = 1'b1;
    cycle();
    checks++; if (s_ack0 !== 1'b1) begin failures++; $display("FAIL mid_first_ack: got %b want 1", s_ack0); end
    bus.req0 = 1'b0;
    repeat (3) cycle();
    checks++; if (s_grant !== 2'b01) begin failures++; $display("FAIL mid_busy_grant: got %b want 01", s_grant); end
    #2 resetq = 1'b0;
    #1;
    checks++;
    if (bus.tx_wr !== 1'b0 || {bus.ack1, bus.ack0} !== 2'b00 || bus.grant !== 2'b00 ||
        bus.tx_data !== 8'h00 || bus.timeout !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outs: tx_wr %b ack %b grant %b data %h timeout %b want 0/00/00/00/0",
               bus.tx_wr, {bus.ack1, bus.ack0}, bus.grant, bus.tx_data, bus.timeout);
    end
    model_on = 1'b0; start_pending = 1'b0; busy_left = 0; bus.tx_busy = 1'b0;
    acks = 0;
    repeat (3) begin
      cycle();
      if (s_ack0 || s_ack1) acks++;
    end
    checks++; if (acks != 0) begin failures++; $display("FAIL mid_no_ack: got %0d acks want 0", acks); end
    resetq = 1'b1;
    bus.data0 = 8'h6B; bus.req0 = 1'b1;
    cycle();
    checks++; if (s_tx_wr !== 1'b1 || s_ack0 !== 1'b1) begin failures++; $display("FAIL mid_fresh_wr: tx_wr %b ack0 %b want 1/1", s_tx_wr, s_ack0); end
    checks++; if (s_tx_data !== 8'h6B) begin failures++; $display("FAIL mid_fresh_data: got %h want 6B", s_tx_data); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_timeout();
    test_busy_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
